// File: rtl/pdh_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pdh_dma_pkg
// Brief    : Shared state encoding and AXI3 burst constants for the PDH DMAs
// Revision : 1.0 - initial release
// ============================================================================
package pdh_dma_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [3:0]  BURST_LEN = 4'd15;
    localparam logic [2:0]  BEAT_SIZE = 3'd3;
    localparam logic [1:0]  BURST_INC = 2'b01;
    localparam logic [31:0] ADDR_INC  = 32'd128;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

endpackage
`default_nettype wire

// File: rtl/dma_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_reader_if
// Brief    : AXI3 read-address / read-data channel bundle for the DMA reader
// Revision : 1.0 - initial release
// ============================================================================
interface dma_reader_if;

    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [3:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic [63:0] m_axi_rdata;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;

    modport master (
        output m_axi_araddr, m_axi_arvalid, m_axi_arlen, m_axi_arsize,
               m_axi_arburst, m_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rresp,
               m_axi_rlast
    );

    modport slave (
        input  m_axi_araddr, m_axi_arvalid, m_axi_arlen, m_axi_arsize,
               m_axi_arburst, m_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rresp,
               m_axi_rlast
    );

endinterface
`default_nettype wire

// File: rtl/posedge_detector.sv
`default_nettype none
// ============================================================================
// Module   : posedge_detector
// Brief    : Registers a level once and pulses for one cycle on its rising edge
// Revision : 1.0 - initial release
// ============================================================================
module posedge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic pulse_o
);

    logic sig_q, sig_d;
    logic prev_q, prev_d;

    always_comb begin
        sig_d  = sig_i;
        prev_d = sig_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sig_q  <= sig_d;
            prev_q <= prev_d;
        end
    end

    assign pulse_o = sig_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/dma_reader.sv
`default_nettype none
// ============================================================================
// Module   : dma_reader
// Brief    : AXI3 read master copying a DDR region into BRAM in 16x64-bit
//            INCR bursts, with per-burst retry. PDH_DMA_RD_PERF_EN adds
//            cycle and retry counters.
// Revision : 1.0 - initial release
// ============================================================================
module dma_reader
    import pdh_dma_pkg::*;
#(
    parameter logic [31:0] HP0_BASE_ADDR = 32'h1000_0000,
    parameter logic [31:0] DMA_SIZE      = 32'h0002_0000,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic               aclk,
    input  logic               rst_ni,
    dma_reader_if.master       axi,
    input  logic               enable_i,
    output logic [31:0]        bram_addr_o,
    output logic [63:0]        bram_data_o,
    output logic               bram_we_o,
    output logic               finished_o,
    output logic               dma_engaged_o,
    output logic               error_o
`ifdef PDH_DMA_RD_PERF_EN
    ,
    output logic [31:0]        perf_cycles_o,
    output logic [15:0]        retry_total_o
`endif
);

    localparam logic [31:0] END_ADDR    = HP0_BASE_ADDR + DMA_SIZE - 32'd1;
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [4:0]  beat_q, beat_d;
    logic [7:0]  retry_q, retry_d;
    logic        bad_q, bad_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [63:0] wdata_q, wdata_d;

    logic start;
    logic beat_fire;
    logic beat_bad;
    logic last_exp;
    logic idle_like;

    posedge_detector u_start_det (
        .clk     (aclk),
        .rst_n   (rst_ni),
        .sig_i   (enable_i),
        .pulse_o (start)
    );

    assign beat_fire = (state_q == R) && axi.m_axi_rvalid;
    assign beat_bad  = (axi.m_axi_rresp != RESP_OKAY);
    assign last_exp  = (beat_q == {1'b0, BURST_LEN});
    assign idle_like = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        beat_d   = beat_q;
        retry_d  = retry_q;
        bad_d    = bad_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d  = AR;
                    araddr_d = HP0_BASE_ADDR;
                    beat_d   = '0;
                    retry_d  = '0;
                end
            end
            AR: begin
                if (axi.m_axi_arready) begin
                    state_d = R;
                    beat_d  = '0;
                    bad_d   = 1'b0;
                end
            end
            R: begin
                if (beat_fire) begin
                    beat_d = beat_q + 5'd1;
                    if (beat_bad) begin
                        bad_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = ((araddr_q - HP0_BASE_ADDR) >> 3) + {27'd0, beat_q};
                        wdata_d = axi.m_axi_rdata;
                    end
                    // Burst ends on rlast or on the 16th beat; both must coincide.
                    if (axi.m_axi_rlast || last_exp) begin
                        if (axi.m_axi_rlast != last_exp) begin
                            state_d = ERR;
                        end else if (bad_q || beat_bad) begin
                            if (retry_q < RETRY_LIMIT) begin
                                retry_d = retry_q + 8'd1;
                                state_d = AR;
                            end else begin
                                state_d = ERR;
                            end
                        end else if (araddr_q + ADDR_INC > END_ADDR) begin
                            state_d = DONE;
                        end else begin
                            araddr_d = araddr_q + ADDR_INC;
                            retry_d  = '0;
                            state_d  = AR;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            araddr_q <= HP0_BASE_ADDR;
            beat_q   <= '0;
            retry_q  <= '0;
            bad_q    <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            beat_q   <= beat_d;
            retry_q  <= retry_d;
            bad_q    <= bad_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign axi.m_axi_araddr  = araddr_q;
    assign axi.m_axi_arvalid = (state_q == AR);
    assign axi.m_axi_arlen   = BURST_LEN;
    assign axi.m_axi_arsize  = BEAT_SIZE;
    assign axi.m_axi_arburst = BURST_INC;
    assign axi.m_axi_rready  = (state_q == R);

    assign bram_we_o     = we_q;
    assign bram_addr_o   = waddr_q;
    assign bram_data_o   = wdata_q;
    assign finished_o    = (state_q == DONE);
    assign error_o       = (state_q == ERR);
    assign dma_engaged_o = (state_q == AR) || (state_q == R);

`ifdef PDH_DMA_RD_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic [15:0] rtot_q, rtot_d;

    always_comb begin
        perf_d = perf_q;
        rtot_d = rtot_q;
        if (idle_like && (state_d == AR)) begin
            perf_d = '0;
            rtot_d = '0;
        end else begin
            if (dma_engaged_o && (perf_q != '1)) perf_d = perf_q + 32'd1;
            // A retry is the only path that bumps the retry count by one.
            if ((state_q == R) && (retry_d == retry_q + 8'd1) && (rtot_q != '1))
                rtot_d = rtot_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
            rtot_q <= '0;
        end else begin
            perf_q <= perf_d;
            rtot_q <= rtot_d;
        end
    end

    assign perf_cycles_o = perf_q;
    assign retry_total_o = rtot_q;
`else
    logic unused_idle_like;
    assign unused_idle_like = idle_like;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_reader
// Brief    : Self-checking bench: AXI3 read slave model plus BRAM scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_reader;
    import pdh_dma_pkg::*;

    localparam logic [31:0] BASE    = 32'h1000_0000;
    localparam logic [31:0] SIZE    = 32'd256;
    localparam int          RETRIES = 3;

    typedef struct {
        int    ar_delay;
        bit    gaps;
        int    err_mode;
        int    rlast_beat;
        int    exp_ar;
        int    exp_wr;
        bit    exp_fin;
        bit    exp_err;
        string name;
    } case_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    logic aclk = 1'b0;
    logic rst_ni;
    logic enable_i;
    logic [31:0] bram_addr_o;
    logic [63:0] bram_data_o;
    logic bram_we_o, finished_o, dma_engaged_o, error_o;
`ifdef PDH_DMA_RD_PERF_EN
    logic [31:0] perf_cycles_o;
    logic [15:0] retry_total_o;
`endif

    dma_reader_if axi ();

    dma_reader #(
        .HP0_BASE_ADDR (BASE),
        .DMA_SIZE      (SIZE),
        .MAX_RETRIES   (RETRIES)
    ) dut (
        .aclk          (aclk),
        .rst_ni        (rst_ni),
        .axi           (axi),
        .enable_i      (enable_i),
        .bram_addr_o   (bram_addr_o),
        .bram_data_o   (bram_data_o),
        .bram_we_o     (bram_we_o),
        .finished_o    (finished_o),
        .dma_engaged_o (dma_engaged_o),
        .error_o       (error_o)
`ifdef PDH_DMA_RD_PERF_EN
        ,
        .perf_cycles_o (perf_cycles_o),
        .retry_total_o (retry_total_o)
`endif
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    case_t cases[5];
    case_t cur;
    wr_t   sb_q[$];
    wr_t   e;

    // slave / model state, shared with the main process for reset
    logic [31:0] model_addr;
    int          attempt, beat, wait_cnt, ar_cnt, wr_cnt;
    int          wr_hist[32];
    bit          busy, bad, pend, ar_wait_prev;
    logic [31:0] ar_prev_addr;
    bit          ar_hs, r_hs, ar_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_idx(input logic [31:0] a, input int b);
        return ((a - BASE) >> 3) + 32'(b);
    endfunction

    function automatic logic [63:0] word_data(input logic [31:0] w, input int att);
        return {16'hCAFE, 8'(att), w[7:0], ~(w * 32'h9E37_79B9)};
    endfunction

    function automatic bit beat_err(input int mode);
        if (mode == 2) return 1'b1;
        if (mode == 1) return (model_addr == BASE + 32'd128) && (attempt == 0) && (beat == 7);
        return 1'b0;
    endfunction

    // AXI read slave plus write monitor; decisions at negedge, drive after posedge
    initial begin : slave
        axi.m_axi_arready = 1'b0;
        axi.m_axi_rvalid  = 1'b0;
        axi.m_axi_rdata   = '0;
        axi.m_axi_rresp   = '0;
        axi.m_axi_rlast   = 1'b0;
        forever begin
            @(negedge aclk);
            if (pend || bram_we_o) begin
                check("bram_we_latency", bram_we_o, pend);
                if (bram_we_o) begin
                    wr_cnt++;
                    if (bram_addr_o < 32) wr_hist[bram_addr_o[4:0]]++;
                end
                if (pend) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: got empty queue, expected an entry");
                    end else begin
                        e = sb_q.pop_front();
                        if (bram_we_o) begin
                            check("bram_addr", bram_addr_o, e.addr);
                            check("bram_data", bram_data_o, e.data);
                        end
                    end
                end
            end
            pend    = 1'b0;
            ar_hs   = axi.m_axi_arvalid && axi.m_axi_arready;
            r_hs    = axi.m_axi_rvalid && axi.m_axi_rready;
            ar_seen = axi.m_axi_arvalid;
            if (ar_wait_prev) begin
                check("arvalid_hold", axi.m_axi_arvalid, 1);
                check("araddr_hold", axi.m_axi_araddr, ar_prev_addr);
            end
            ar_wait_prev = axi.m_axi_arvalid && !axi.m_axi_arready;
            ar_prev_addr = axi.m_axi_araddr;
            if (ar_hs) begin
                ar_cnt++;
                check("ar_addr", axi.m_axi_araddr, model_addr);
            end
            if (r_hs && axi.m_axi_rresp == RESP_OKAY) begin
                pend = 1'b1;
                sb_q.push_back('{word_idx(model_addr, beat),
                                 word_data(word_idx(model_addr, beat), attempt)});
            end

            @(posedge aclk);
            #1;
            if (ar_hs) begin
                axi.m_axi_arready = 1'b0;
                busy = 1'b1;
                beat = 0;
                bad  = 1'b0;
                wait_cnt = 0;
            end else if (!busy && ar_seen) begin
                wait_cnt++;
            end
            if (busy) begin
                if (r_hs) begin
                    if (axi.m_axi_rresp != RESP_OKAY) bad = 1'b1;
                    if (axi.m_axi_rlast) begin
                        busy = 1'b0;
                        axi.m_axi_rvalid = 1'b0;
                        axi.m_axi_rlast  = 1'b0;
                        wait_cnt = 0;
                        if (bad) attempt++;
                        else begin
                            model_addr = model_addr + 32'd128;
                            attempt = 0;
                        end
                    end else begin
                        beat++;
                    end
                end
                if (busy && (r_hs || !axi.m_axi_rvalid)) begin
                    axi.m_axi_rvalid = cur.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                    axi.m_axi_rdata  = word_data(word_idx(model_addr, beat), attempt);
                    axi.m_axi_rresp  = beat_err(cur.err_mode) ? 2'b10 : RESP_OKAY;
                    axi.m_axi_rlast  = (beat == cur.rlast_beat);
                end
            end
            if (!busy) axi.m_axi_arready = (wait_cnt >= cur.ar_delay);
        end
    end

    task automatic clear_model();
        ar_cnt = 0;
        wr_cnt = 0;
        foreach (wr_hist[k]) wr_hist[k] = 0;
        model_addr = BASE;
        attempt = 0;
    endtask

    task automatic run_case(input case_t c);
        int cyc;
        int once;
        @(posedge aclk);
        #3;
        cur = c;
        clear_model();
        enable_i = 1'b1;
        cyc = 0;
        while (!dma_engaged_o && cyc < 50) begin
            @(posedge aclk);
            #3;
            cyc++;
        end
        if (!dma_engaged_o) begin
            checks++;
            errors++;
            $display("FAIL %s start_timeout: got engaged=0, expected 1", c.name);
        end
        cyc = 0;
        while (!(finished_o || error_o) && cyc < 5000) begin
            @(posedge aclk);
            #3;
            cyc++;
        end
        repeat (4) @(posedge aclk);
        #3;
        enable_i = 1'b0;
        check({c.name, ":finished"}, finished_o, c.exp_fin);
        check({c.name, ":error"}, error_o, c.exp_err);
        check({c.name, ":engaged"}, dma_engaged_o, 0);
        check({c.name, ":ar_count"}, ar_cnt, c.exp_ar);
        check({c.name, ":write_count"}, wr_cnt, c.exp_wr);
        check({c.name, ":sb_left"}, sb_q.size(), 0);
        if (c.exp_wr == 32) begin
            once = 0;
            foreach (wr_hist[k]) if (wr_hist[k] == 1) once++;
            check({c.name, ":each_word_once"}, once, 32);
        end
        if (c.err_mode == 1) begin
            check({c.name, ":word23_writes"}, wr_hist[23], 1);
            check({c.name, ":word16_writes"}, wr_hist[16], 2);
        end
        repeat (3) @(posedge aclk);
    endtask

    initial begin : main
        int cyc;
        cases[0] = '{0, 1'b0, 0, 15, 2, 32, 1'b1, 1'b0, "zero_wait"};
        cases[1] = '{5, 1'b1, 0, 15, 2, 32, 1'b1, 1'b0, "wait_gaps"};
        cases[2] = '{0, 1'b0, 1, 15, 3, 47, 1'b1, 1'b0, "slverr_b2_beat7"};
        cases[3] = '{0, 1'b1, 2, 15, 4, 0,  1'b0, 1'b1, "slverr_all"};
        cases[4] = '{0, 1'b0, 0, 10, 1, 11, 1'b0, 1'b1, "early_rlast"};
        cur = cases[0];
        busy = 0; bad = 0; pend = 0; ar_wait_prev = 0; beat = 0; wait_cnt = 0;
        ar_prev_addr = '0;
        clear_model();
        enable_i = 1'b0;
        rst_ni   = 1'b0;
        repeat (3) @(posedge aclk);
        #3;
        check("rst_arvalid", axi.m_axi_arvalid, 0);
        check("rst_rready", axi.m_axi_rready, 0);
        check("rst_araddr", axi.m_axi_araddr, BASE);
        check("rst_arlen", axi.m_axi_arlen, 15);
        check("rst_arsize", axi.m_axi_arsize, 3);
        check("rst_arburst", axi.m_axi_arburst, 1);
        check("rst_status", {bram_we_o, finished_o, error_o, dma_engaged_o}, 0);
        check("rst_bram", {bram_addr_o, bram_data_o[31:0]}, 0);
        rst_ni = 1'b1;
        repeat (2) @(posedge aclk);

        for (int i = 0; i < 5; i++) run_case(cases[i]);

        // reset during beat 5 of the first burst, then restart
        @(posedge aclk);
        #3;
        cur = cases[0];
        clear_model();
        enable_i = 1'b1;
        cyc = 0;
        while (!(busy && beat == 5 && model_addr == BASE) && cyc < 200) begin
            @(posedge aclk);
            #3;
            cyc++;
        end
        check("reset_seq:reached_beat5", beat, 5);
        rst_ni   = 1'b0;
        enable_i = 1'b0;
        busy = 0; pend = 0; ar_wait_prev = 0; wait_cnt = 0;
        axi.m_axi_rvalid  = 1'b0;
        axi.m_axi_rlast   = 1'b0;
        axi.m_axi_arready = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_arvalid", axi.m_axi_arvalid, 0);
        check("midrst_rready", axi.m_axi_rready, 0);
        check("midrst_araddr", axi.m_axi_araddr, BASE);
        check("midrst_status", {bram_we_o, finished_o, error_o, dma_engaged_o}, 0);
        check("midrst_bram_addr", bram_addr_o, 0);
        check("midrst_bram_data", bram_data_o, 0);
        repeat (2) @(posedge aclk);
        #3;
        rst_ni = 1'b1;
        run_case(cases[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
